ppu_frame_sync: RTL and testbench

- Upstream neighbour of the PPU.
- Generates 640x480@60 VGA pixel timing: hcount/vcount, syncs, blank, frame/line pulses.
- Buffers host register writes (address/writedata) in a FIFO and replays them to the PPU only during vertical blank, so sprite state never changes mid-frame (no tearing).
- Sits between the Avalon slave and the PPU plus sprite display modules.

---
 rtl/ppu_frame_sync_pkg.sv | 30 +++
 rtl/ppu_frame_sync_if.sv | 14 +
 rtl/ppu_frame_sync_wr_fifo.sv | 57 +++++
 rtl/ppu_frame_sync.sv | 165 ++++++++++++++++
 tb/tb_ppu_frame_sync.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ppu_frame_sync_pkg.sv
// ppu_frame_sync_pkg.sv
// Shared VGA timing constants and the replayed-write record used by the
// frame-synchronised register path in front of the PPU.
package ppu_pkg;

    // Default 640x480@60 timing components
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Derived totals and sync windows (end is exclusive)
    localparam int H_TOTAL      = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL      = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + DEF_H_SYNC;
    localparam int V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + DEF_V_SYNC;

    // One host register write as held in the pending-write FIFO
    typedef struct packed {
        logic [2:0]  addr;
        logic [31:0] data;
    } ppu_wr_t;

endpackage

// File: rtl/ppu_frame_sync_if.sv
// ppu_frame_sync_if.sv
// Avalon-style host register write bus feeding ppu_frame_sync.
// The host drives through the master modport, ppu_frame_sync listens on slave.
interface ppu_frame_sync_if;

    logic        chipselect;
    logic        write;
    logic [2:0]  address;
    logic [31:0] writedata;

    modport master (output chipselect, output write, output address, output writedata);
    modport slave  (input  chipselect, input  write, input  address, input  writedata);

endinterface

// File: rtl/ppu_frame_sync_wr_fifo.sv
// ppu_frame_sync_wr_fifo.sv
// Synchronous FIFO holding pending host writes. Pointers carry one extra
// wrap bit so full and empty are told apart by comparing the MSBs.
// A push while full is accepted only when a pop happens in the same clk.
module ppu_wr_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Storage write port
    // NOTE: the RAM has no reset; emptiness is defined by the pointers alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // Read/write pointers, flushed by reset or clear
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/ppu_frame_sync.sv
// ppu_frame_sync.sv
// VGA pixel timing generator plus a write buffer that replays host register
// writes to the PPU only during vertical blank, so sprite state never
// changes mid-frame.
// Optional feature: define PPU_FRAME_SYNC_BYPASS_EN to add a bypass input
// that forwards host writes straight through (registered) and keeps the
// FIFO empty.
module ppu_frame_sync
    import ppu_pkg::*;
#(
    parameter int CLK_DIV    = 2,
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              reset,
`ifdef PPU_FRAME_SYNC_BYPASS_EN
    input  logic              bypass,
`endif
    ppu_frame_sync_if.slave   host,
    output logic [9:0]        hcount,
    output logic [9:0]        vcount,
    output logic              pix_en,
    output logic              hsync_n,
    output logic              vsync_n,
    output logic              blank_n,
    output logic              frame_start,
    output logic              ppu_wr,
    output logic [2:0]        ppu_address,
    output logic [31:0]       ppu_writedata,
    output logic              fifo_ovf
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div_cnt;
    logic             vblank;
    logic             host_wr;
    logic             bypass_on;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    ppu_wr_t          host_entry;
    ppu_wr_t          fifo_head;

`ifdef PPU_FRAME_SYNC_BYPASS_EN
    assign bypass_on = bypass;
`else
    assign bypass_on = 1'b0;
`endif

    assign host_wr         = host.chipselect && host.write;
    assign host_entry.addr = host.address;
    assign host_entry.data = host.writedata;
    assign fifo_push       = host_wr && !bypass_on;
    assign fifo_pop        = vblank && !fifo_empty && !bypass_on;

    // Pixel divider: pix_en marks the clk following a divider wrap
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
            pix_en  <= 1'b0;
        end else begin
            pix_en <= (div_cnt == DIV_LAST);
            if (div_cnt == DIV_LAST) div_cnt <= '0;
            else                     div_cnt <= div_cnt + 1'b1;
        end
    end

    // Raster counters and the frame_start pulse on the wrap into (0,0)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hcount      <= '0;
            vcount      <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= pix_en && (hcount == H_LAST) && (vcount == V_LAST);
            if (pix_en) begin
                if (hcount == H_LAST) begin
                    hcount <= '0;
                    vcount <= (vcount == V_LAST) ? '0 : vcount + 1'b1;
                end else begin
                    hcount <= hcount + 1'b1;
                end
            end
        end
    end

    // Sync, blank and vblank decode from the registered counters
    // NOTE: every output is given a default first so no latch is inferred.
    always_comb begin
        hsync_n = 1'b1;
        vsync_n = 1'b1;
        blank_n = 1'b0;
        vblank  = 1'b0;
        if (hcount >= HS_START && hcount < HS_END) hsync_n = 1'b0;
        if (vcount >= VS_START && vcount < VS_END) vsync_n = 1'b0;
        if (hcount < H_ACT && vcount < V_ACT)      blank_n = 1'b1;
        if (vcount >= V_ACT)                       vblank  = 1'b1;
    end

    // Sticky overflow: a push into a full FIFO that no pop makes room for
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fifo_ovf <= 1'b0;
        end else if (fifo_push && fifo_full && !fifo_pop) begin
            fifo_ovf <= 1'b1;
        end
    end

    // Replay register towards the PPU: one strobe per popped (or bypassed) write
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ppu_wr        <= 1'b0;
            ppu_address   <= '0;
            ppu_writedata <= '0;
        end else if (bypass_on) begin
            ppu_wr <= host_wr;
            if (host_wr) begin
                ppu_address   <= host_entry.addr;
                ppu_writedata <= host_entry.data;
            end
        end else begin
            ppu_wr <= fifo_pop;
            if (fifo_pop) begin
                ppu_address   <= fifo_head.addr;
                ppu_writedata <= fifo_head.data;
            end
        end
    end

    ppu_wr_fifo #(
        .WIDTH ($bits(ppu_wr_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .clear   (bypass_on),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (host_entry),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_ppu_frame_sync.sv
// tb_ppu_frame_sync.sv
// Self-checking bench for ppu_frame_sync using a shrunken raster so several
// frames fit in a short run. Expected raster values come from the number of
// clock edges since reset; expected PPU writes come from a queue model of the
// pending-write buffer and are checked by a separate monitor process.
module tb_ppu_frame_sync;
    import ppu_pkg::*;

    localparam int CD = 2;
    localparam int HA = 16, HF = 2, HS = 4, HB = 2;
    localparam int VA = 8,  VF = 2, VS = 2, VB = 2;
    localparam int DEPTH = 16;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME_CLKS = HT * VT * CD;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [9:0]  hcount, vcount;
    logic        pix_en, hsync_n, vsync_n, blank_n, frame_start;
    logic        ppu_wr, fifo_ovf;
    logic [2:0]  ppu_address;
    logic [31:0] ppu_writedata;

    ppu_frame_sync_if bus ();

    ppu_frame_sync #(
        .CLK_DIV (CD), .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB), .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
`ifdef PPU_FRAME_SYNC_BYPASS_EN
        .bypass        (1'b0),
`endif
        .host          (bus.slave),
        .hcount        (hcount),
        .vcount        (vcount),
        .pix_en        (pix_en),
        .hsync_n       (hsync_n),
        .vsync_n       (vsync_n),
        .blank_n       (blank_n),
        .frame_start   (frame_start),
        .ppu_wr        (ppu_wr),
        .ppu_address   (ppu_address),
        .ppu_writedata (ppu_writedata),
        .fifo_ovf      (fifo_ovf)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        ppu_wr_t e;
        int      due;
    } exp_t;

    int      n = 0;        // rising edges since reset release
    ppu_wr_t mq[$];        // writes waiting for vblank
    exp_t    sb[$];        // writes expected on ppu_wr, with the edge count they appear at
    bit      m_ovf = 1'b0;

    function automatic int pixels(input int k);
        return (k < 1) ? 0 : (k - 1) / CD;
    endfunction
    function automatic int m_h(input int k);
        return pixels(k) % HT;
    endfunction
    function automatic int m_v(input int k);
        return (pixels(k) / HT) % VT;
    endfunction
    function automatic bit m_pix(input int k);
        return (k >= CD) && (k % CD == 0);
    endfunction
    function automatic bit m_fs(input int k);
        return (k >= 1) && (pixels(k) > 0) && (pixels(k) != pixels(k - 1))
               && (pixels(k) % (HT * VT) == 0);
    endfunction

    // One rising edge: vblank drains one entry, host write appends if room
    task automatic model_edge(input bit push, input ppu_wr_t e);
        bit      pop;
        bit      room;
        ppu_wr_t out;
        pop  = (m_v(n) >= VA) && (mq.size() > 0);
        room = mq.size() < DEPTH;
        if (pop) out = mq.pop_front();
        if (push) begin
            if (room || pop) mq.push_back(e);
            else             m_ovf = 1'b1;
        end
        n++;
        if (pop) sb.push_back('{e: out, due: n});
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step(input bit cs, input bit wr, input logic [2:0] a, input logic [31:0] d);
        ppu_wr_t e;
        bus.chipselect = cs;
        bus.write      = wr;
        bus.address    = a;
        bus.writedata  = d;
        e.addr = a;
        e.data = d;
        @(posedge clk);
        if (reset) model_edge(cs && wr, e);
        #1;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 3'd0, 32'd0);
    endtask

    task automatic idle_until_line(input int v);
        int guard = 0;
        while (m_v(n) != v && guard < 2 * FRAME_CLKS) begin
            step(1'b0, 1'b0, 3'd0, 32'd0);
            guard++;
        end
        check("wait_line_bound", guard < 2 * FRAME_CLKS, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_hcount"}, hcount, 0);
        check({tag, "_vcount"}, vcount, 0);
        check({tag, "_syncs"}, {pix_en, hsync_n, vsync_n, blank_n, frame_start}, 5'b01110);
        check({tag, "_ppu"}, {ppu_wr, ppu_address, ppu_writedata}, 36'd0);
        check({tag, "_ovf"}, fifo_ovf, 0);
    endtask

    // Asynchronous reset away from any clock edge, checked before the next edge
    task automatic do_reset(input int hold);
        #2 reset = 1'b0;
        #1;
        n = 0;
        mq.delete();
        sb.delete();
        m_ovf = 1'b0;
        check_reset_outputs("async_reset");
        idle(hold);
        reset = 1'b1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            check("hcount", hcount, m_h(n));
            check("vcount", vcount, m_v(n));
            check("timing{pix_en,hsync_n,vsync_n,blank_n,frame_start}",
                  {pix_en, hsync_n, vsync_n, blank_n, frame_start},
                  {m_pix(n),
                   !(m_h(n) >= HA + HF && m_h(n) < HA + HF + HS),
                   !(m_v(n) >= VA + VF && m_v(n) < VA + VF + VS),
                   (m_h(n) < HA && m_v(n) < VA),
                   m_fs(n)});
            check("fifo_ovf", fifo_ovf, m_ovf);
            if (sb.size() > 0 && sb[0].due <= n) begin
                x = sb.pop_front();
                check("ppu_wr", ppu_wr, 1);
                check("ppu_address", ppu_address, x.e.addr);
                check("ppu_writedata", ppu_writedata, x.e.data);
            end else begin
                check("ppu_wr_idle", ppu_wr, 0);
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
        bus.address    = 3'd0;
        bus.writedata  = 32'd0;
        #3;
        check_reset_outputs("por");
        idle(3);
        reset = 1'b1;

        // Idle raster over two frames
        idle(2 * FRAME_CLKS);

        // Single write during active video waits for vblank
        idle_until_line(3);
        step(1'b1, 1'b1, 3'd3, 32'h00A0_0050);
        idle_until_line(VA + 1);
        idle_until_line(0);

        // 17 writes in active video: the last is dropped and flags overflow
        idle_until_line(1);
        idle_until_line(0);
        for (int i = 0; i < 17; i++) step(1'b1, 1'b1, 3'(i), 32'(i));
        idle_until_line(VA + 1);

        // Write during vblank into an empty FIFO
        step(1'b1, 1'b1, 3'd5, 32'hDEAD_0005);
        idle(4);
        // Chipselect or write alone must not capture anything
        step(1'b1, 1'b0, 3'd6, 32'h1111_1111);
        step(1'b0, 1'b1, 3'd7, 32'h2222_2222);
        idle(4);

        // Fill to full, then push and pop together at the start of vblank
        do_reset(2);
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 3'(i + 1), 32'hC000_0000 + 32'(i));
        idle_until_line(VA);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 3'(i), 32'hE000_0000 + 32'(i));
        idle_until_line(0);

        // Randomised traffic over three frames
        for (int i = 0; i < 3 * FRAME_CLKS; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0),
                 3'($urandom), $urandom);
        end

        // Reset with pending entries mid-frame: nothing is replayed afterwards
        do_reset(2);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 3'(i), 32'hBAD0_0000 + 32'(i));
        idle_until_line(5);
        do_reset(3);
        idle_until_line(VA + 1);
        idle_until_line(0);

        idle(8);
        check("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
